layer_argmax_16: RTL and testbench

- Classifier back-end that sits directly downstream of a layer_N_M_P_T block.
- Consumes the layer's output stream over a valid/ready handshake, in groups of N signed T-bit values (one group per input vector).
- Emits one result per group: the index of the largest value and that value.
- Its slave port connects directly to the layer's m_valid/m_ready/data_out.

---
 rtl/layer_argmax_16.sv | 79 +++++++
 tb/tb_layer_argmax_16.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_argmax_16.sv
// Argmax back-end for a layer output stream: consumes groups of N signed values
// over valid/ready and emits the index and value of the first maximum per group.
module layer_argmax_16 #(
  parameter  int T  = 16,
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [IW-1:0]       idx_out,
  output logic signed [T-1:0] max_out
);

  typedef enum logic {ACCUM, OUT} state_t;

  state_t              state_q;
  logic [IW-1:0]       cnt_q;
  logic [IW-1:0]       best_idx_q;
  logic signed [T-1:0] best_val_q;
  logic [IW-1:0]       idx_q;
  logic signed [T-1:0] max_q;

  logic                last;
  logic                take;
  logic [IW-1:0]       best_idx_d;
  logic signed [T-1:0] best_val_d;

  // Element 0 always seeds the running best; later ones must be strictly greater
  // so that ties keep the earliest index.
  always_comb begin
    last       = (cnt_q == IW'(N - 1));
    take       = (cnt_q == '0) || (data_in > best_val_q);
    best_idx_d = take ? cnt_q : best_idx_q;
    best_val_d = take ? data_in : best_val_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      idx_q      <= '0;
      max_q      <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (s_valid) begin
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            if (last) begin
              idx_q   <= best_idx_d;
              max_q   <= best_val_d;
              cnt_q   <= '0;
              state_q <= OUT;
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end
        end
        OUT: begin
          if (m_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign s_ready = (state_q == ACCUM) && !reset;
  assign m_valid = (state_q == OUT);
  assign idx_out = idx_q;
  assign max_out = max_q;

endmodule

// File: tb/tb_layer_argmax_16.sv
// Scoreboard bench for layer_argmax_16: the driver queues expected results per
// group, an independent monitor pops and compares on every output handshake.
module tb_layer_argmax_16;

  typedef logic [15:0] grp_t [16];

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] data_in;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  idx_out;
  logic [15:0] max_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  int          mr_mode = 0;   // 0: m_ready=1, 1: random, 2: m_ready=0
  logic [19:0] exp_q[$];

  layer_argmax_16 #(.T(16), .N(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output-side handshake driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every result handshake consumes one scoreboard entry
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got idx=%0d max=0x%04h, expected none", idx_out, max_out);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        n_pop++;
        check("result", {12'd0, idx_out, max_out}, {12'd0, e});
      end
    end
  end

  task automatic push(input logic [15:0] v, input bit rnd);
    int unsigned guard;
    logic rdy;
    guard = 0;
    if (rnd) begin
      while ($urandom_range(3) == 0) begin
        s_valid = 1'b0;
        data_in = 'x;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    data_in = v;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      guard++;
      if (guard > 500) begin
        $display("FAIL accept_timeout: got no s_ready, expected acceptance within 500 cycles");
        $fatal(1, "stalled");
      end
    end
    s_valid = 1'b0;
    data_in = 'x;
  endtask

  task automatic send(input grp_t g, input logic [3:0] ei, input logic [15:0] em,
                      input bit rnd, input bit queue_it);
    if (queue_it) exp_q.push_back({ei, em});
    for (int unsigned i = 0; i < 16; i++) push(g[i], rnd);
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [19:0] model(input grp_t g);
    logic [3:0]  bi;
    logic [15:0] bv;
    bi = 4'd0;
    bv = g[0];
    for (int unsigned i = 1; i < 16; i++) begin
      if ($signed(g[i]) > $signed(bv)) begin
        bv = g[i];
        bi = 4'(i);
      end
    end
    return {bi, bv};
  endfunction

  initial begin
    grp_t g;
    logic [19:0] e;
    int pop0;

    reset   = 1'b1;
    s_valid = 1'b0;
    data_in = 'x;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_idx", idx_out, 0);
    check("rst_max", max_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ascending group: result one cycle after 16th accept, s_ready low that cycle only
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'(i);
    send(g, 4'd15, 16'h000F, 1'b0, 1'b1);
    check("asc_m_valid_hi", m_valid, 1);
    check("asc_s_ready_lo", s_ready, 0);
    @(posedge clk);
    #1;
    check("asc_m_valid_lo", m_valid, 0);
    check("asc_s_ready_hi", s_ready, 1);

    // Descending, then all -5
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'(15 - i);
    send(g, 4'd0, 16'h000F, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'hFFFB;
    send(g, 4'd0, 16'hFFFB, 1'b0, 1'b1);

    // Sign handling and ties
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'h8000;
    g[7]  = 16'h0001;
    g[12] = 16'h0001;
    send(g, 4'd7, 16'h0001, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'h8000;
    send(g, 4'd0, 16'h8000, 1'b0, 1'b1);
    drain();

    // Backpressure: result held, no input consumed
    mr_mode = 2;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'h0010;
    g[4]  = 16'h1234;
    g[10] = 16'h1234;
    send(g, 4'd4, 16'h1234, 1'b0, 1'b1);
    s_valid = 1'b1;
    data_in = 16'h7FFF;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_m_valid", m_valid, 1);
      check("bp_s_ready", s_ready, 0);
      check("bp_hold", {idx_out, max_out}, {4'd4, 16'h1234});
    end
    s_valid = 1'b0;
    data_in = 'x;
    mr_mode = 0;
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'hFFFF;
    g[3] = 16'h0000;
    send(g, 4'd3, 16'h0000, 1'b0, 1'b1);
    drain();

    // Reset mid-group discards the partial group
    push(16'h0001, 1'b0);
    push(16'h7FFF, 1'b0);
    push(16'h0002, 1'b0);
    push(16'h0003, 1'b0);
    push(16'h0004, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_s_ready", s_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'hFFF0;
    g[0]  = 16'h0002;
    g[9]  = 16'h0003;
    g[13] = 16'h0003;
    send(g, 4'd9, 16'h0003, 1'b0, 1'b1);
    drain();

    // Reset while a result is pending drops it immediately
    mr_mode = 2;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 16; i++) g[i] = 16'(i);
    send(g, 4'd15, 16'h000F, 1'b0, 1'b0);
    check("out_pending", m_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_out_m_valid", m_valid, 0);
    check("rst_out_idx", idx_out, 0);
    @(negedge clk);
    reset = 1'b0;
    mr_mode = 0;
    @(posedge clk);
    #1;

    // Random stress against the reference model
    mr_mode = 1;
    pop0 = n_pop;
    for (int unsigned k = 0; k < 1000; k++) begin
      for (int unsigned i = 0; i < 16; i++) g[i] = 16'($urandom);
      if (k % 7 == 0) g[$urandom_range(15)] = 16'h8000;
      if (k % 11 == 0) g[$urandom_range(15)] = g[$urandom_range(15)];
      e = model(g);
      send(g, e[19:16], e[15:0], 1'b1, 1'b1);
    end
    drain();
    check("stress_count", n_pop - pop0, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
